// File: rtl/pg_load_monitor_pkg.sv
// Shared types, defaults and the per-port count qualifier for the
// power-gating load monitor.
package pg_load_monitor_pkg;

    localparam int PORT_STAT_SIZE = 2;

    typedef enum logic [PORT_STAT_SIZE-1:0] {
        ST_INACTIVE = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_WAKEUP   = 2'd2,
        ST_SLEEP    = 2'd3
    } port_stat_e;

    localparam int          PG_NUM_PORTS   = 4;
    localparam int          PG_CNT_W       = 8;
    localparam int          PG_EPOCH_LEN   = 0;
    localparam int          PG_ALPHA_SHIFT = 2;
    localparam int unsigned PG_HI_TH       = 192;
    localparam int unsigned PG_LO_TH       = 32;

    // A powered port counts real flits; a gated port counts flits that
    // would have been routed to it, so wake-up pressure is still visible.
    function automatic logic count_qualify(input logic                      flit_valid,
                                           input logic                      productive,
                                           input logic [PORT_STAT_SIZE-1:0] status);
        return (flit_valid && (status == ST_ACTIVE)) ||
               (productive && (status == ST_INACTIVE));
    endfunction

endpackage

// File: rtl/pg_load_monitor_if.sv
// Router-side inputs and published load outputs of one load monitor.
interface pg_load_monitor_if #(
    parameter int NUM_PORTS = 4,
    parameter int CNT_W     = 8,
    parameter int SUM_W     = CNT_W + $clog2(NUM_PORTS)
);
    import pg_load_monitor_pkg::*;

    // No backpressure: loadValid is a one-cycle publish strobe and the
    // published values stay held until the next strobe.
    logic                                sample;
    logic [NUM_PORTS-1:0]                valid;
    logic [NUM_PORTS-1:0]                productiveVector;
    logic [NUM_PORTS*PORT_STAT_SIZE-1:0] portStatus;
    logic [NUM_PORTS*CNT_W-1:0]          portLoad;
    logic [SUM_W-1:0]                    routerLoad;
    logic [SUM_W-1:0]                    avgLoad;
    logic                                loadValid;
    logic [NUM_PORTS-1:0]                portHot;
    logic [NUM_PORTS-1:0]                portCold;

    modport master (
        output sample, valid, productiveVector, portStatus,
        input  portLoad, routerLoad, avgLoad, loadValid, portHot, portCold
    );

    modport slave (
        input  sample, valid, productiveVector, portStatus,
        output portLoad, routerLoad, avgLoad, loadValid, portHot, portCold
    );

endinterface

// File: rtl/pg_load_monitor_port_util_counter.sv
// Saturating per-port utilisation counter; close_value includes this
// cycle's event so a close cycle never drops it.
module port_util_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] close_value
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_comb begin
        close_value = (count == CNT_MAX) ? CNT_MAX : count + CNT_W'(inc);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= close_value;
        end
    end

endmodule

// File: rtl/pg_load_monitor.sv
// Per-router load monitor: epoch timing, load summation, EWMA smoothing
// and hot/cold hysteresis on top of per-port utilisation counters.
module pg_load_monitor
    import pg_load_monitor_pkg::*;
#(
    parameter int          NUM_PORTS   = PG_NUM_PORTS,
    parameter int          CNT_W       = PG_CNT_W,
    parameter int          EPOCH_LEN   = PG_EPOCH_LEN,
    parameter int          ALPHA_SHIFT = PG_ALPHA_SHIFT,
    parameter int unsigned HI_TH       = PG_HI_TH,
    parameter int unsigned LO_TH       = PG_LO_TH
) (
    input logic              clk,
    input logic              reset,
    pg_load_monitor_if.slave bus
);

    localparam int SUM_W = CNT_W + $clog2(NUM_PORTS);
    localparam int EP_W  = $clog2(EPOCH_LEN + 1);
    localparam int TMR_W = (EP_W < 1) ? 1 : EP_W;

    logic [NUM_PORTS-1:0]       inc;
    logic [CNT_W-1:0]           count     [NUM_PORTS];
    logic [CNT_W-1:0]           close_val [NUM_PORTS];
    logic [NUM_PORTS*CNT_W-1:0] close_flat;
    logic                       close;

    logic [NUM_PORTS*CNT_W-1:0] port_load_q;
    logic [SUM_W-1:0]           router_load_q;
    logic [SUM_W-1:0]           avg_load_q;
    logic                       load_valid_q;
    logic [NUM_PORTS-1:0]       hot_q;
    logic [NUM_PORTS-1:0]       cold_q;
    logic                       ewma_init_q;

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_port
        assign inc[j] = count_qualify(bus.valid[j], bus.productiveVector[j],
                                      bus.portStatus[j*PORT_STAT_SIZE +: PORT_STAT_SIZE]);

        port_util_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk         (clk),
            .reset       (reset),
            .inc         (inc[j]),
            .clear       (close),
            .count       (count[j]),
            .close_value (close_val[j])
        );
    end

    if (EPOCH_LEN == 0) begin : g_ext_close
        assign close = bus.sample;
    end else begin : g_timer_close
        localparam logic [TMR_W-1:0] LAST = TMR_W'(EPOCH_LEN - 1);
        logic [TMR_W-1:0] timer;

        always_ff @(posedge clk) begin
            if (!reset) begin
                timer <= '0;
            end else if (timer == LAST) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end

        assign close = (timer == LAST);
    end

    logic [SUM_W-1:0]        sum;
    logic signed [SUM_W:0]   diff;
    logic signed [SUM_W:0]   ewma_step;
    logic signed [SUM_W:0]   ewma_sum;
    logic [SUM_W-1:0]        ewma_next;
    logic [NUM_PORTS-1:0]    hot_next;
    logic [NUM_PORTS-1:0]    cold_next;

    always_comb begin
        sum        = '0;
        close_flat = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            sum                          = sum + SUM_W'(close_val[j]);
            close_flat[j*CNT_W +: CNT_W] = close_val[j];
        end
    end

    // The step lies between old avg and new sum, so the result never leaves
    // the unsigned SUM_W range and the top bit can be dropped.
    always_comb begin
        diff      = $signed({1'b0, sum}) - $signed({1'b0, avg_load_q});
        ewma_step = diff >>> ALPHA_SHIFT;
        ewma_sum  = $signed({1'b0, avg_load_q}) + ewma_step;
        ewma_next = ewma_sum[SUM_W-1:0];
    end

    always_comb begin
        hot_next  = hot_q;
        cold_next = cold_q;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (32'(close_val[j]) >= HI_TH) begin
                hot_next[j]  = 1'b1;
                cold_next[j] = 1'b0;
            end else if (32'(close_val[j]) <= LO_TH) begin
                hot_next[j]  = 1'b0;
                cold_next[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            port_load_q   <= '0;
            router_load_q <= '0;
            avg_load_q    <= '0;
            load_valid_q  <= 1'b0;
            hot_q         <= '0;
            cold_q        <= '0;
            ewma_init_q   <= 1'b0;
        end else begin
            load_valid_q <= close;
            if (close) begin
                port_load_q   <= close_flat;
                router_load_q <= sum;
                avg_load_q    <= ewma_init_q ? ewma_next : sum;
                ewma_init_q   <= 1'b1;
                hot_q         <= hot_next;
                cold_q        <= cold_next;
            end
        end
    end

    assign bus.portLoad   = port_load_q;
    assign bus.routerLoad = router_load_q;
    assign bus.avgLoad    = avg_load_q;
    assign bus.loadValid  = load_valid_q;
    assign bus.portHot    = hot_q;
    assign bus.portCold   = cold_q;

endmodule

// File: tb/tb_pg_load_monitor.sv
// Directed bench for pg_load_monitor: external-sample, saturating and
// internal-timer configurations checked against hand-computed values.
module tb_pg_load_monitor;
    import pg_load_monitor_pkg::*;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pg_load_monitor_if #(.NUM_PORTS(4), .CNT_W(8)) if_a ();
    pg_load_monitor_if #(.NUM_PORTS(4), .CNT_W(4)) if_b ();
    pg_load_monitor_if #(.NUM_PORTS(4), .CNT_W(8)) if_c ();

    pg_load_monitor #(.NUM_PORTS(4), .CNT_W(8), .EPOCH_LEN(0), .ALPHA_SHIFT(2),
                      .HI_TH(192), .LO_TH(32)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    pg_load_monitor #(.NUM_PORTS(4), .CNT_W(4), .EPOCH_LEN(0), .ALPHA_SHIFT(2),
                      .HI_TH(12), .LO_TH(2)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
    pg_load_monitor #(.NUM_PORTS(4), .CNT_W(8), .EPOCH_LEN(8), .ALPHA_SHIFT(2),
                      .HI_TH(192), .LO_TH(32)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] stat4(input port_stat_e s3, input port_stat_e s2,
                                         input port_stat_e s1, input port_stat_e s0);
        return {s3, s2, s1, s0};
    endfunction

    initial begin
        reset = 1'b0;
        if_a.sample = 1'b0; if_a.valid = '0; if_a.productiveVector = '0; if_a.portStatus = '0;
        if_b.sample = 1'b0; if_b.valid = '0; if_b.productiveVector = '0; if_b.portStatus = '0;
        if_c.sample = 1'b0; if_c.valid = '0; if_c.productiveVector = '0; if_c.portStatus = '0;
        step();
        step();

        // Reset state
        check("rst_portLoad", if_a.portLoad, 0);
        check("rst_routerLoad", if_a.routerLoad, 0);
        check("rst_avgLoad", if_a.avgLoad, 0);
        check("rst_loadValid", if_a.loadValid, 0);
        check("rst_hot", if_a.portHot, 0);
        check("rst_cold", if_a.portCold, 0);
        reset = 1'b1;

        // 1: ten ACTIVE flits on port0, sample on the tenth
        if_a.portStatus = stat4(ST_SLEEP, ST_SLEEP, ST_SLEEP, ST_ACTIVE);
        if_a.valid = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            if_a.sample = (i == 9);
            step();
            if (i == 8) check("t1_no_early_valid", if_a.loadValid, 0);
        end
        check("t1_portLoad", if_a.portLoad, 64'h0000_000A);
        check("t1_routerLoad", if_a.routerLoad, 10);
        check("t1_avgLoad", if_a.avgLoad, 10);
        check("t1_loadValid", if_a.loadValid, 1);
        check("t1_cold", if_a.portCold, 4'b1111);
        check("t1_hot", if_a.portHot, 4'b0000);
        if_a.valid = '0;
        if_a.sample = 1'b0;
        step();
        check("t1_loadValid_drop", if_a.loadValid, 0);
        check("t1_portLoad_hold", if_a.portLoad, 64'h0000_000A);

        // 2: INACTIVE port1 counts productive only; WAKEUP port2 counts nothing
        if_a.portStatus = stat4(ST_SLEEP, ST_WAKEUP, ST_INACTIVE, ST_SLEEP);
        if_a.valid = 4'b0110;
        if_a.productiveVector = 4'b0100;
        for (int i = 0; i < 5; i++) step();
        if_a.productiveVector = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            if_a.sample = (i == 2);
            step();
        end
        check("t2_portLoad", if_a.portLoad, 64'h0000_0300);
        check("t2_routerLoad", if_a.routerLoad, 3);
        check("t2_avgLoad", if_a.avgLoad, 8);
        check("t2_loadValid", if_a.loadValid, 1);
        if_a.sample = 1'b0;
        if_a.valid = '0;
        if_a.productiveVector = '0;

        // 6: reset mid-epoch discards the partial count and re-inits the EWMA
        if_a.portStatus = stat4(ST_SLEEP, ST_SLEEP, ST_SLEEP, ST_ACTIVE);
        if_a.valid = 4'b0001;
        for (int i = 0; i < 6; i++) step();
        reset = 1'b0;
        step();
        check("t6_rst_portLoad", if_a.portLoad, 0);
        check("t6_rst_routerLoad", if_a.routerLoad, 0);
        check("t6_rst_avgLoad", if_a.avgLoad, 0);
        check("t6_rst_loadValid", if_a.loadValid, 0);
        check("t6_rst_cold", if_a.portCold, 0);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if_a.sample = (i == 1);
            step();
        end
        check("t6_portLoad", if_a.portLoad, 64'h0000_0002);
        check("t6_routerLoad", if_a.routerLoad, 2);
        check("t6_avgLoad", if_a.avgLoad, 2);
        check("t6_loadValid", if_a.loadValid, 1);
        if_a.sample = 1'b0;
        if_a.valid = '0;

        // 5: EWMA 100 then 0, then hysteresis with 200/200/200 then 200/100/20
        reset = 1'b0;
        step();
        reset = 1'b1;
        if_a.valid = 4'b0001;
        for (int i = 0; i < 100; i++) begin
            if_a.sample = (i == 99);
            step();
        end
        check("t5_router_100", if_a.routerLoad, 100);
        check("t5_avg_100", if_a.avgLoad, 100);
        check("t5_hot_mid", if_a.portHot, 4'b0000);
        check("t5_cold_mid", if_a.portCold, 4'b1110);
        if_a.valid = '0;
        if_a.sample = 1'b1;
        step();
        check("t5_router_0", if_a.routerLoad, 0);
        check("t5_avg_75", if_a.avgLoad, 75);
        check("t5_b2b_loadValid", if_a.loadValid, 1);
        check("t5_cold_0", if_a.portCold, 4'b1111);
        if_a.portStatus = stat4(ST_SLEEP, ST_ACTIVE, ST_ACTIVE, ST_ACTIVE);
        if_a.valid = 4'b0111;
        for (int i = 0; i < 200; i++) begin
            if_a.sample = (i == 199);
            step();
        end
        check("t5_portLoad_600", if_a.portLoad, 64'h00C8_C8C8);
        check("t5_router_600", if_a.routerLoad, 600);
        check("t5_avg_206", if_a.avgLoad, 206);
        check("t5_hot_all", if_a.portHot, 4'b0111);
        check("t5_cold_all", if_a.portCold, 4'b1000);
        for (int i = 0; i < 200; i++) begin
            if_a.valid = {1'b0, (i < 20), (i < 100), 1'b1};
            if_a.sample = (i == 199);
            step();
        end
        check("t5_portLoad_mix", if_a.portLoad, 64'h0014_64C8);
        check("t5_router_320", if_a.routerLoad, 320);
        check("t5_avg_234", if_a.avgLoad, 234);
        check("t5_hot_mix", if_a.portHot, 4'b0011);
        check("t5_cold_mix", if_a.portCold, 4'b1100);
        if_a.valid = '0;
        if_a.sample = 1'b0;

        // 3: CNT_W=4 saturation at 15, then a fresh 2-event epoch
        reset = 1'b0;
        step();
        reset = 1'b1;
        if_b.portStatus = stat4(ST_SLEEP, ST_ACTIVE, ST_SLEEP, ST_SLEEP);
        if_b.valid = 4'b0100;
        for (int i = 0; i < 40; i++) begin
            if_b.sample = (i == 39);
            step();
        end
        check("t3_portLoad_sat", if_b.portLoad, 64'h0F00);
        check("t3_router_sat", if_b.routerLoad, 15);
        check("t3_avg_sat", if_b.avgLoad, 15);
        check("t3_hot_sat", if_b.portHot, 4'b0100);
        check("t3_cold_sat", if_b.portCold, 4'b1011);
        for (int i = 0; i < 2; i++) begin
            if_b.sample = (i == 1);
            step();
        end
        check("t3_portLoad_2", if_b.portLoad, 64'h0200);
        check("t3_router_2", if_b.routerLoad, 2);
        check("t3_avg_11", if_b.avgLoad, 11);
        check("t3_hot_2", if_b.portHot, 4'b0000);
        check("t3_cold_2", if_b.portCold, 4'b1111);
        if_b.valid = '0;
        if_b.sample = 1'b0;

        // 4: EPOCH_LEN=8 timer closes every 8 cycles; sample is ignored
        if_c.portStatus = stat4(ST_ACTIVE, ST_ACTIVE, ST_ACTIVE, ST_ACTIVE);
        if_c.valid = 4'b1111;
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            if_c.sample = 1'($urandom_range(0, 1));
            step();
            check($sformatf("t4_loadValid_%0d", k), if_c.loadValid, (k % 8 == 0) ? 1 : 0);
            if (k % 8 == 0) begin
                check($sformatf("t4_portLoad_%0d", k), if_c.portLoad, 64'h0808_0808);
                check($sformatf("t4_router_%0d", k), if_c.routerLoad, 32);
                check($sformatf("t4_avg_%0d", k), if_c.avgLoad, 32);
            end
        end
        if_c.valid = '0;
        if_c.sample = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
